// File: rtl/bcd_scan_display_pkg.sv
// Shared constants and types for the multiplexed BCD scan display.
// Segment encodings are active-high, bit 0 = segment a ... bit 6 = segment g.
package bcd_scan_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef logic [1:0] digit_idx_t;

    // True when any of the four nibbles is not a legal BCD digit.
    function automatic logic has_invalid_digit(input logic [15:0] d);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (d[k*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [3:0] idx_to_an(input digit_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        // NOTE: a default on every path keeps this purely combinational (no latch).
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit time-multiplexed BCD display driver with snapshot register and error flag.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        err
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [15:0]   r_snap;
    logic [PW-1:0] r_presc;
    digit_idx_t    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_err;

    logic          w_presc_wrap;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg_dec;
    logic [6:0]    w_seg_next;

    assign w_presc_wrap = (r_presc == PW'(SCAN_DIV - 1));
    assign w_digit      = r_snap[{r_idx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic w_blank;

    // A digit is blanked only when it and every more significant digit are zero.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd3:    w_blank = (r_snap[15:12] == 4'd0);
            2'd2:    w_blank = (r_snap[15:8]  == 8'd0);
            2'd1:    w_blank = (r_snap[15:4]  == 12'd0);
            default: w_blank = 1'b0;
        endcase
    end

    assign w_seg_next = w_blank ? SEG_BLANK : w_seg_dec;
`else
    assign w_seg_next = w_seg_dec;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_snap  <= '0;
            r_presc <= '0;
            r_idx   <= '0;
            r_an    <= '0;
            r_seg   <= SEG_BLANK;
            r_err   <= 1'b0;
        end else begin
            // Outputs follow the pre-edge index and snapshot, so a load that lands
            // on an index wrap is first seen on the digit selected after the wrap.
            r_an  <= idx_to_an(r_idx);
            r_seg <= w_seg_next;
            if (w_presc_wrap) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            if (load) begin
                r_snap <= digits;
                r_err  <= has_invalid_digit(digits);
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign err = r_err;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed self-checking bench for bcd_scan_display at SCAN_DIV=4 and SCAN_DIV=2.
// Expected segment patterns follow LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_bcd_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  an,  an2;
    logic [6:0]  seg, seg2;
    logic        err, err2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_scan_display #(.SCAN_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .digits(digits), .load(load),
        .an(an), .seg(seg), .err(err)
    );

    bcd_scan_display #(.SCAN_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .digits(digits), .load(load),
        .an(an2), .seg(seg2), .err(err2)
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Digit select must never have more than one bit set.
    always @(negedge clk) begin
        check("an_onehot0", 16'($onehot0(an)), 16'd1);
        check("an2_onehot0", 16'($onehot0(an2)), 16'd1);
    end

    // One full scan frame (16 cycles at SCAN_DIV=4, two frames at SCAN_DIV=2),
    // optionally loading new digits on the last edge, which is also an index wrap.
    task automatic run_frame(input string tag,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic exp_err, input logic ld,
                             input logic [15:0] nd, input logic nxt_err);
        logic [6:0] s [4];
        logic       e;
        s = '{s0, s1, s2, s3};
        for (int k = 0; k < 16; k++) begin
            if (k == 15 && ld) begin
                load   = 1'b1;
                digits = nd;
            end
            step();
            load = 1'b0;
            e = (k == 15 && ld) ? nxt_err : exp_err;
            check({tag, "_an"},   16'(an),   16'(4'b0001 << (k / 4)));
            check({tag, "_seg"},  16'(seg),  16'(s[k / 4]));
            check({tag, "_err"},  16'(err),  16'(e));
            check({tag, "_an2"},  16'(an2),  16'(4'b0001 << ((k / 2) % 4)));
            check({tag, "_seg2"}, 16'(seg2), 16'(s[(k / 2) % 4]));
            check({tag, "_err2"}, 16'(err2), 16'(e));
        end
    endtask

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        digits = 16'h0000;
        step();
        // Reset must win over a simultaneous load of invalid digits.
        load   = 1'b1;
        digits = 16'hFFFF;
        step();
        check("rst_an",   16'(an),   16'h0);
        check("rst_seg",  16'(seg),  16'h0);
        check("rst_err",  16'(err),  16'h0);
        check("rst_an2",  16'(an2),  16'h0);
        check("rst_err2", 16'(err2), 16'h0);

        rst    = 1'b0;
        load   = 1'b0;
        digits = 16'h0000;

`ifdef LEADING_ZERO_BLANK_EN
        run_frame("idle",  7'h3F, 7'h00, 7'h00, 7'h00, 1'b0, 1'b1, 16'h1985, 1'b0);
        run_frame("d1985", 7'h6D, 7'h7F, 7'h6F, 7'h06, 1'b0, 1'b1, 16'h00A7, 1'b1);
        run_frame("d00A7", 7'h07, 7'h40, 7'h00, 7'h00, 1'b1, 1'b1, 16'h0007, 1'b0);
        run_frame("d0007", 7'h07, 7'h00, 7'h00, 7'h00, 1'b0, 1'b1, 16'h0400, 1'b0);
        run_frame("d0400", 7'h3F, 7'h3F, 7'h66, 7'h00, 1'b0, 1'b1, 16'h0040, 1'b0);
        run_frame("d0040", 7'h3F, 7'h66, 7'h00, 7'h00, 1'b0, 1'b0, 16'h0000, 1'b0);
`else
        run_frame("idle",  7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b1, 16'h1985, 1'b0);
        run_frame("d1985", 7'h6D, 7'h7F, 7'h6F, 7'h06, 1'b0, 1'b1, 16'h00A7, 1'b1);
        run_frame("d00A7", 7'h07, 7'h40, 7'h3F, 7'h3F, 1'b1, 1'b1, 16'h0007, 1'b0);
        run_frame("d0007", 7'h07, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b1, 16'h0400, 1'b0);
        run_frame("d0400", 7'h3F, 7'h3F, 7'h66, 7'h3F, 1'b0, 1'b1, 16'h0040, 1'b0);
        run_frame("d0040", 7'h3F, 7'h66, 7'h3F, 7'h3F, 1'b0, 1'b0, 16'h0000, 1'b0);
`endif

        // Mid-scan reset while digit2 is selected; snapshot 0040 must be discarded.
        for (int k = 0; k < 9; k++) step();
        check("mid_an_pre", 16'(an), 16'h4);
        rst = 1'b1;
        step();
        check("mid_rst_an",  16'(an),  16'h0);
        check("mid_rst_seg", 16'(seg), 16'h0);
        check("mid_rst_err", 16'(err), 16'h0);
        rst = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        run_frame("post", 7'h3F, 7'h00, 7'h00, 7'h00, 1'b0, 1'b0, 16'h0000, 1'b0);
`else
        run_frame("post", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b0, 16'h0000, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
